// File: rtl/pps_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pps_pkg
// Purpose  : Shared types, widths and the period-window helper for the PPS
//            conditioning block.
// Revision : 1.0 - initial release
// ============================================================================
package pps_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam int ERR_W = 16;
  localparam int SEC_W = 32;

  // True when interval n lies inside hz +/- tol (inclusive). Written as
  // n + tol >= hz so that a tolerance larger than hz cannot underflow.
  function automatic logic in_window(input logic [63:0] n,
                                     input logic [63:0] hz,
                                     input logic [63:0] tol);
    return ((n + tol) >= hz) && (n <= (hz + tol));
  endfunction

endpackage
`default_nettype wire

// File: rtl/pps_edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : pps_edge_sync
// Purpose  : Two-flop synchroniser for an asynchronous strobe followed by a
//            rising-edge detector. A level held high yields a single edge.
// Revision : 1.0 - initial release
// ============================================================================
module pps_edge_sync (
  input  logic CLK,
  input  logic RST,
  input  logic i_d,
  output logic o_edge
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // Shift the raw input through two metastability flops plus one history flop.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_edge = r_s2 & ~r_s3;

endmodule
`default_nettype wire

// File: rtl/pps_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : pps_sync_gen
// Purpose  : PPS conditioner. Synchronises the external PPS, validates its
//            period, emits a one-cycle second strobe plus a stretched output,
//            and free-runs local holdover seconds when the reference is lost.
// Revision : 1.0 - initial release
// ============================================================================
module pps_sync_gen
  import pps_pkg::*;
#(
  parameter int CLK_HZ     = 125000000,
  parameter int TOL        = 1000,
  parameter int CNT_W      = 32,
  parameter int PULSE_W    = 12500000,
  parameter int MISS_LIMIT = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             pps_in,
  input  logic             force_local,
  output logic             pps_pulse,
  output logic             pps_out,
  output logic             locked,
  output logic             holdover,
  output logic             lost,
  output logic [CNT_W-1:0] period,
  output logic [ERR_W-1:0] err_count,
  output logic [SEC_W-1:0] sec_count
);

  // One extra bit so that cnt+1 never wraps when cnt is saturated.
  localparam int N_W    = CNT_W + 1;
  localparam int MISS_W = (MISS_LIMIT < 1) ? 1 : $clog2(MISS_LIMIT + 1);
  localparam int PW_W   = (PULSE_W < 2) ? 1 : $clog2(PULSE_W + 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [MISS_W-1:0] r_miss;
  logic              r_pulse;
  logic              r_lost;
  logic [CNT_W-1:0]  r_period;
  logic [ERR_W-1:0]  r_err;
  logic [SEC_W-1:0]  r_sec;
  logic              r_force_d;
  logic              r_out;
  logic [PW_W-1:0]   r_wcnt;

  logic              w_edge;
  logic [N_W-1:0]    w_n;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [ERR_W-1:0]  w_err_inc;
  logic [SEC_W-1:0]  w_sec_inc;
  logic              w_in_win;
  logic              w_timeout;
  logic              w_tick;
  logic              w_local;
  logic              w_force_rise;

  pps_edge_sync u_edge (
    .CLK    (CLK),
    .RST    (RST),
    .i_d    (pps_in),
    .o_edge (w_edge)
  );

  assign w_n          = {1'b0, r_cnt} + N_W'(1);
  assign w_cnt_inc    = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_err_inc    = (r_err == '1) ? r_err : r_err + ERR_W'(1);
  assign w_sec_inc    = r_sec + SEC_W'(1);
  assign w_in_win     = in_window(64'(w_n), 64'(CLK_HZ), 64'(TOL));
  assign w_timeout    = (w_n == N_W'(CLK_HZ + TOL));
  assign w_tick       = (w_n == {1'b0, r_period});
  assign w_local      = (w_n == N_W'(CLK_HZ));
  assign w_force_rise = force_local & ~r_force_d;

  // Acquisition / lock / holdover FSM with its interval counter and stats.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_miss    <= '0;
      r_pulse   <= 1'b0;
      r_lost    <= 1'b0;
      r_period  <= CNT_W'(CLK_HZ);
      r_err     <= '0;
      r_sec     <= '0;
      r_force_d <= 1'b0;
    end else begin
      r_force_d <= force_local;
      r_pulse   <= 1'b0;
      r_cnt     <= w_cnt_inc;
      if (force_local) begin
        // Local free-run: the reference is ignored, seconds come from cnt.
        r_state <= IDLE;
        if (w_force_rise) begin
          r_cnt <= '0;
        end else if (w_local) begin
          r_pulse <= 1'b1;
          r_sec   <= w_sec_inc;
          r_cnt   <= '0;
        end
      end else begin
        case (r_state)
          IDLE: begin
            if (w_edge) begin
              r_state <= ACQ;
              r_cnt   <= '0;
            end
          end
          ACQ: begin
            if (w_edge) begin
              r_cnt <= '0;
              if (w_in_win) begin
                r_state  <= LOCK;
                r_period <= w_n[CNT_W-1:0];
                r_pulse  <= 1'b1;
                r_sec    <= w_sec_inc;
                r_lost   <= 1'b0;
              end else begin
                r_err <= w_err_inc;
              end
            end
          end
          LOCK: begin
            if (w_edge && w_in_win) begin
              r_period <= w_n[CNT_W-1:0];
              r_pulse  <= 1'b1;
              r_sec    <= w_sec_inc;
              r_cnt    <= '0;
            end else if (w_edge) begin
              // Early edge is a glitch: counted, but the second keeps running.
              r_err <= w_err_inc;
            end else if (w_timeout) begin
              r_state <= HOLD;
              r_pulse <= 1'b1;
              r_sec   <= w_sec_inc;
              r_cnt   <= '0;
              r_miss  <= MISS_W'(1);
            end
          end
          HOLD: begin
            if (w_edge) begin
              r_state <= ACQ;
              r_cnt   <= '0;
            end else if (w_tick) begin
              r_cnt <= '0;
              if (r_miss == MISS_W'(MISS_LIMIT)) begin
                r_state <= IDLE;
                r_lost  <= 1'b1;
              end else begin
                r_pulse <= 1'b1;
                r_sec   <= w_sec_inc;
                r_miss  <= r_miss + MISS_W'(1);
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Stretch each strobe into a PULSE_W-cycle output; a new strobe restarts it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_out  <= 1'b0;
      r_wcnt <= '0;
    end else if (r_pulse) begin
      r_out  <= 1'b1;
      r_wcnt <= PW_W'(PULSE_W - 1);
    end else if (r_wcnt != '0) begin
      r_wcnt <= r_wcnt - PW_W'(1);
    end else begin
      r_out <= 1'b0;
    end
  end

  assign pps_pulse = r_pulse;
  assign pps_out   = r_out;
  assign locked    = (r_state == LOCK);
  assign holdover  = (r_state == HOLD);
  assign lost      = r_lost;
  assign period    = r_period;
  assign err_count = r_err;
  assign sec_count = r_sec;

endmodule
`default_nettype wire

// File: tb/tb_pps_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pps_sync_gen
// Purpose  : Self-checking bench for pps_sync_gen against a timestamp-based
//            behavioural model, with directed and randomised PPS patterns.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pps_sync_gen;

  localparam int HZ = 1000;
  localparam int TL = 10;
  localparam int PW = 5;
  localparam int ML = 2;

  localparam int ST_IDLE = 0;
  localparam int ST_ACQ  = 1;
  localparam int ST_LOCK = 2;
  localparam int ST_HOLD = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        pps_in;
  logic        force_local;
  logic        pps_pulse;
  logic        pps_out;
  logic        locked;
  logic        holdover;
  logic        lost;
  logic [31:0] period;
  logic [15:0] err_count;
  logic [31:0] sec_count;

  int checks = 0;
  int errors = 0;

  pps_sync_gen #(
    .CLK_HZ     (HZ),
    .TOL        (TL),
    .CNT_W      (32),
    .PULSE_W    (PW),
    .MISS_LIMIT (ML)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .pps_in      (pps_in),
    .force_local (force_local),
    .pps_pulse   (pps_pulse),
    .pps_out     (pps_out),
    .locked      (locked),
    .holdover    (holdover),
    .lost        (lost),
    .period      (period),
    .err_count   (err_count),
    .sec_count   (sec_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (timestamps, not counters) ----------
  longint cyc = 0;
  longint t_clr;            // cycle at which the interval reference restarted
  bit     h1, h2, h3;       // pps_in seen at the last three clock edges
  int     m_st;
  bit     m_pulse, m_out, m_lost, m_fprev, out_valid;
  longint m_period, m_err, m_sec, out_start;
  int     m_miss;

  task automatic model_reset();
    t_clr = cyc; h1 = 0; h2 = 0; h3 = 0;
    m_st = ST_IDLE; m_pulse = 0; m_out = 0; m_lost = 0; m_fprev = 0;
    out_valid = 0; m_period = HZ; m_err = 0; m_sec = 0; m_miss = 0; out_start = 0;
  endtask

  task automatic model_step();
    longint n;
    bit e, pulse, clr, win;
    cyc++;
    n = cyc - t_clr;
    if (n > 64'h1_0000_0000) n = 64'h1_0000_0000;
    e = h2 && !h3;
    h3 = h2; h2 = h1; h1 = pps_in;
    if (m_pulse) begin out_start = cyc; out_valid = 1; end
    m_out = out_valid && ((cyc - out_start) < PW);
    win = (n >= HZ - TL) && (n <= HZ + TL);
    pulse = 0; clr = 0;
    if (force_local) begin
      m_st = ST_IDLE;
      if (!m_fprev) clr = 1;
      else if (n == HZ) begin pulse = 1; clr = 1; end
    end else if (m_st == ST_IDLE) begin
      if (e) begin m_st = ST_ACQ; clr = 1; end
    end else if (m_st == ST_ACQ) begin
      if (e) begin
        clr = 1;
        if (win) begin m_st = ST_LOCK; m_period = n; pulse = 1; m_lost = 0; end
        else if (m_err < 65535) m_err++;
      end
    end else if (m_st == ST_LOCK) begin
      if (e && win) begin m_period = n; pulse = 1; clr = 1; end
      else if (e) begin if (m_err < 65535) m_err++; end
      else if (n == HZ + TL) begin m_st = ST_HOLD; pulse = 1; clr = 1; m_miss = 1; end
    end else begin
      if (e) begin m_st = ST_ACQ; clr = 1; end
      else if (n == m_period) begin
        clr = 1;
        if (m_miss == ML) begin m_st = ST_IDLE; m_lost = 1; end
        else begin pulse = 1; m_miss++; end
      end
    end
    m_fprev = force_local;
    if (clr) t_clr = cyc;
    m_pulse = pulse;
    if (pulse) m_sec = (m_sec + 1) & 64'hFFFF_FFFF;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // ---------------- compare process and pulse-shape monitor ---------------
  bit     rec = 0;
  longint pq[$];
  int     run = 0, last_run = 0;
  longint last_pulse_t = 0, rise_delay = 0;
  bit     prev_out = 0;

  initial begin
    forever begin
      @(negedge clk);
      chk("pps_pulse", pps_pulse, m_pulse);
      chk("pps_out",   pps_out,   m_out);
      chk("locked",    locked,    m_st == ST_LOCK);
      chk("holdover",  holdover,  m_st == ST_HOLD);
      chk("lost",      lost,      m_lost);
      chk("period",    period,    m_period);
      chk("err_count", err_count, m_err);
      chk("sec_count", sec_count, m_sec);
      if (pps_pulse) last_pulse_t = $time;
      if (rec && pps_pulse) pq.push_back($time);
      if (pps_out && !prev_out) rise_delay = ($time - last_pulse_t) / 10;
      if (pps_out) run++;
      else if (prev_out) begin last_run = run; run = 0; end
      prev_out = pps_out;
    end
  end

  // ---------------- stimulus ----------------------------------------------
  // Rising edge now, then k cycles until the caller's next action.
  task automatic fire(input int k);
    int h;
    h = $urandom_range(1, (k > 41) ? 40 : k - 1);
    pps_in = 1'b1;
    repeat (h) @(negedge clk);
    pps_in = 1'b0;
    repeat (k - h) @(negedge clk);
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    longint sec_snap, tf;
    int     npl;
    bit     got;
    rst = 1'b0; pps_in = 1'b0; force_local = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pulse", pps_pulse, 0);
    chk("rst_out", pps_out, 0);
    chk("rst_locked", locked, 0);
    chk("rst_lost", lost, 0);
    chk("rst_period", period, 1000);
    chk("rst_sec", sec_count, 0);
    rst = 1'b0;

    // Acquire then lock at 1000-cycle intervals.
    fire(1000);
    fire(12);
    chk("lock_locked", locked, 1);
    chk("lock_period", period, 1000);
    chk("lock_sec", sec_count, 1);
    chk("out_width", last_run, 5);
    chk("out_delay", rise_delay, 1);
    idle(983);
    // Window edges 995 and 1010 accepted, then a late edge times out.
    fire(12);
    chk("p995", period, 995);
    idle(998);
    fire(12);
    chk("p1010", period, 1010);
    chk("p1010_err", err_count, 0);
    idle(1008);
    chk("timeout_hold", holdover, 1);
    chk("timeout_nolock", locked, 0);
    fire(1000);                  // HOLD -> ACQ
    fire(300);                   // ACQ -> LOCK
    fire(700);                   // glitch at n=300
    fire(12);                    // n=1000 from last good edge
    chk("glitch_err", err_count, 1);
    chk("glitch_locked", locked, 1);
    chk("glitch_period", period, 1000);
    // Reference disappears: holdover ticks then loss.
    idle(4000);
    chk("lost_set", lost, 1);
    chk("lost_locked", locked, 0);
    chk("lost_hold", holdover, 0);
    sec_snap = sec_count;
    idle(1500);
    chk("lost_nopulse", sec_count, sec_snap);
    // Relock, then an edge exactly on a holdover tick.
    fire(1000);
    fire(12);
    chk("relock_lost", lost, 0);
    chk("relock_locked", locked, 1);
    idle(1998);
    sec_snap = sec_count;
    fire(12);
    chk("tick_edge_acq", locked | holdover, 0);
    chk("tick_edge_nopulse", sec_count, sec_snap);
    idle(988);
    fire(12);
    chk("tick_edge_relock", locked, 1);
    idle(988);

    // Randomised intervals: in-window, glitches and late edges.
    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(0, 3))
        0:       fire(HZ - TL + int'($urandom_range(0, 2 * TL)));
        1:       fire(int'($urandom_range(100, 900)));
        2:       fire(int'($urandom_range(1011, 2500)));
        default: fire(int'($urandom_range(985, 1015)));
      endcase
    end

    // Forced local seconds with a noisy reference.
    force_local = 1'b1;
    tf = $time;
    pq.delete();
    rec = 1'b1;
    for (int i = 0; i < 3500; i++) begin
      pps_in = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    pps_in = 1'b0;
    rec = 1'b0;
    npl = 0;
    foreach (pq[i]) begin
      if (pq[i] > tf) begin
        npl++;
        chk("force_pulse_time", pq[i] - tf, 10010 + (npl - 1) * 10000);
      end
    end
    chk("force_npulse", npl, 3);
    chk("force_locked", locked, 0);

    // Asynchronous reset in the middle of a stretched pulse.
    got = 1'b0;
    for (int i = 0; i < 1500 && !got; i++) begin
      @(negedge clk);
      if (pps_pulse) got = 1'b1;
    end
    chk("force_pulse_seen", got, 1);
    @(negedge clk);
    chk("pre_rst_out", pps_out, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out", pps_out, 0);
    chk("arst_pulse", pps_pulse, 0);
    chk("arst_sec", sec_count, 0);
    chk("arst_err", err_count, 0);
    chk("arst_period", period, 1000);
    @(negedge clk);
    rst = 1'b0;
    force_local = 1'b0;
    fire(1000);
    fire(1000);
    fire(1000);
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pps_sync_gen.md
Name: pps_sync_gen

Overview:
- Conditions the single-ended PPS signal delivered by the platform's differential input buffer, in the platform time domain.
- Synchronises the signal, detects its edges and validates their period against the nominal clock rate.
- Produces a one-cycle second strobe for the timebase and a stretched pps_out for the output buffer.
- Carries on with local holdover ticks when the external PPS disappears.

Parameters:
- CLK_HZ, 125000000: nominal CLK cycles per second.
- TOL, 1000: allowed period deviation, in cycles (±).
- CNT_W, 32: width of the interval counter and of period. Must hold CLK_HZ+TOL.
- PULSE_W, 12500000: pps_out high time, in cycles.
- MISS_LIMIT, 2: number of consecutive holdover ticks before lock is declared lost.

Ports:
- CLK  in  1  single clock.
- RST  in  1  asynchronous, active-high reset.
- pps_in  in  1  raw PPS, asynchronous to CLK.
- force_local  in  1  ignore pps_in and free-run local seconds.
- pps_pulse  out  1  one-cycle second strobe.
- pps_out  out  1  stretched PPS, to the output buffer.
- locked  out  1  FSM is in LOCK.
- holdover  out  1  FSM is in HOLD.
- lost  out  1  sticky; set when holdover expires.
- period  out  CNT_W  last accepted interval, in cycles.
- err_count  out  16  saturating count of rejected edges.
- sec_count  out  32  count of pps_pulse strobes; wraps.

Behaviour:
- Reset values: all outputs 0; period = CLK_HZ; FSM in IDLE; cnt = 0.
- Synchroniser: two flops, then an edge flop.
  - edge = s2 & ~s3.
  - A rising edge on pps_in asserts edge 2-3 cycles later.
  - A level held high produces exactly one edge.
- cnt: increments every cycle and saturates at all-ones. Interval n = cnt+1, evaluated in the cycle edge=1. Window W is CLK_HZ-TOL <= n <= CLK_HZ+TOL.
- FSM states: IDLE, ACQ, LOCK, HOLD.
- IDLE:
  - edge -> ACQ, cnt<=0, no pulse.
- ACQ:
  - edge with n in W -> LOCK, period<=n, pps_pulse, cnt<=0, lost<=0.
  - edge with n outside W -> stay in ACQ, err_count++, cnt<=0.
- LOCK:
  - edge with n in W: period<=n, pps_pulse, cnt<=0.
  - edge with n < CLK_HZ-TOL: glitch. Ignored, err_count++, cnt is not reset.
  - no edge and n == CLK_HZ+TOL -> HOLD, pps_pulse, cnt<=0, miss<=1. The phase slip of up to TOL is accepted.
- HOLD:
  - Local tick when n == period: pps_pulse, cnt<=0.
  - On each tick, if miss == MISS_LIMIT -> IDLE and lost<=1 (no pulse on that cycle); otherwise miss++.
  - Any edge -> ACQ, cnt<=0. Edge takes priority over a tick in the same cycle.
- force_local = 1:
  - FSM forced to IDLE; edges ignored.
  - pps_pulse every CLK_HZ cycles from cnt. The first pulse comes CLK_HZ cycles after force_local rises, with cnt cleared on that rising.
  - lost and err_count hold their values.
- force_local falling: FSM starts in IDLE.
- pps_out: registered stretch of pps_pulse.
  - Goes high the cycle after pps_pulse and stays high for PULSE_W cycles.
  - A new pps_pulse while high restarts the width.
- Saturation and wrap: err_count saturates at 0xFFFF; sec_count wraps at 2^32.
- Simultaneous events: an edge coinciding with the LOCK timeout evaluates n == CLK_HZ+TOL, which is in W, so it is accepted and no transition to HOLD occurs.
- Reset mid-operation clears everything immediately (asynchronous); pps_out drops the same instant.

Decomposition:
- Package pps_pkg:
  - state enum {IDLE, ACQ, LOCK, HOLD}.
  - ERR_W=16, SEC_W=32.
  - Helper function in_window(n).
- Sub-module pps_edge_sync (CLK, RST, d, edge): the synchroniser plus edge detect, reusable for other asynchronous strobes.

Test Plan (CLK_HZ=1000, TOL=10, PULSE_W=5, MISS_LIMIT=2):
- Reset, then pps_in edges every 1000 cycles -> first edge ACQ; second edge locked=1, period=1000, sec_count=1; pps_out high 5 cycles starting 1 cycle after pps_pulse.
- In LOCK, edges at intervals 995 then 1010 -> both accepted, period=995 then 1010, err_count=0; interval 1011 -> timeout at n=1010 gives HOLD, holdover=1, pulse.
- In LOCK, glitch edge at n=300, then an edge at n=1000 -> err_count=1, glitch ignored, period=1000, still locked.
- Stop pps_in while in LOCK -> HOLD tick at n=1010, then ticks every period cycles; at miss=2 the next tick gives IDLE, lost=1, no further pulses.
- In HOLD, an edge arrives the same cycle as a tick -> ACQ, no pulse that cycle; next in-window edge -> LOCK, lost=0.
- force_local=1 with pps_in toggling -> pulses exactly every 1000 cycles, locked=0; assert RST mid-pps_out -> every output 0 asynchronously.
